// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock, LSB first, registered inter-digit carry.
// Optional two's-complement overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $error("serial_adder: DIGIT must be nonzero and divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic [DIGIT-1:0] a_sl, b_sl;
   logic [DIGIT:0]   dsum;
   int unsigned      base;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      base = 32'(cnt_q) * DIGIT;
      a_sl = a_q[base +: DIGIT];
      b_sl = b_q[base +: DIGIT];
      dsum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               sum_d   = '0;
               cout_d  = 1'b0;
               cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d[base +: DIGIT] = dsum[DIGIT-1:0];
            carry_d              = dsum[DIGIT];
            if (cnt_q == CW'(NDIG - 1)) begin
               cout_d  = dsum[DIGIT];
               cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
               // a^b^sum at the MSB recovers the carry into it
               ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
`endif
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit/1-bit-digit instance and a 4-bit/2-bit-digit
// instance used for an exhaustive sweep.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic       iv8, ir8, ov8, or8, cin8, co8;
   logic [7:0] a8, b8, s8;
   logic       iv4, ir4, ov4, or4, cin4, co4;
   logic [3:0] a4, b4, s4;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf8, ovf4;
`endif

   serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
      .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_adder #(.WIDTH(4), .DIGIT(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
      .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf4)
`endif
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Accept one operation on dut8 and wait (bounded) for out_valid; lat counts edges after accept.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
      @(negedge clk);
      a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv8 = 1'b0;
      lat = 0;
      while (!ov8 && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic ack8();
      or8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or8 = 1'b0;
   endtask

   int lat;
   logic [4:0] exp4;

   initial begin
      rst_n = 1'b0;
      iv8 = 0; or8 = 0; a8 = '0; b8 = '0; cin8 = 0;
      iv4 = 0; or4 = 0; a4 = '0; b4 = '0; cin4 = 0;
      #12;
      check("rst_in_ready", 32'(ir8), 32'd1);
      check("rst_out_valid", 32'(ov8), 32'd0);
      check("rst_sum", 32'(s8), 32'd0);
      check("rst_cout", 32'(co8), 32'd0);
      check("rst_in_ready4", 32'(ir4), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic add with latency
      op8(8'h3C, 8'h05, 1'b0, lat);
      check("basic_lat", 32'(lat), 32'd8);
      check("basic_sum", 32'(s8), 32'h41);
      check("basic_cout", 32'(co8), 32'd0);
      ack8();
      check("basic_idle_ready", 32'(ir8), 32'd1);
      check("basic_idle_valid", 32'(ov8), 32'd0);

      // Wrap-around
      op8(8'hFF, 8'h00, 1'b1, lat);
      check("wrap_sum", 32'(s8), 32'h00);
      check("wrap_cout", 32'(co8), 32'd1);
      ack8();

      op8(8'h7F, 8'h01, 1'b0, lat);
      check("pos_ovf_sum", 32'(s8), 32'h80);
      check("pos_ovf_cout", 32'(co8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("pos_ovf_ovf", 32'(ovf8), 32'd1);
`endif
      ack8();

      op8(8'hFF, 8'h01, 1'b0, lat);
      check("neg_noovf_sum", 32'(s8), 32'h00);
      check("neg_noovf_cout", 32'(co8), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
      check("neg_noovf_ovf", 32'(ovf8), 32'd0);
`endif
      ack8();

      // Backpressure: result held while out_ready is low
      op8(8'h12, 8'h34, 1'b1, lat);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(ov8), 32'd1);
         check("bp_sum", 32'(s8), 32'h47);
         check("bp_cout", 32'(co8), 32'd0);
         check("bp_in_ready", 32'(ir8), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      ack8();
      check("bp_release_ready", 32'(ir8), 32'd1);
      check("bp_release_valid", 32'(ov8), 32'd0);

      // Operand isolation: inputs change and in_valid toggles during RUN
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; iv8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("iso_cleared_sum", 32'(s8), 32'h00);
      check("iso_busy_ready", 32'(ir8), 32'd0);
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      lat = 0;
      while (!ov8 && lat < 50) begin
         iv8 = ~iv8;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      iv8 = 1'b0;
      check("iso_lat", 32'(lat), 32'd8);
      check("iso_sum", 32'(s8), 32'h30);
      check("iso_cout", 32'(co8), 32'd0);
      ack8();
      @(posedge clk);
      @(negedge clk);
      check("iso_no_second_accept", 32'(ir8), 32'd1);

      // Asynchronous reset during RUN
      @(negedge clk);
      a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0; iv8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_partial_sum", 32'(s8), 32'h07);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(ov8), 32'd0);
      check("mid_rst_sum", 32'(s8), 32'd0);
      check("mid_rst_ready", 32'(ir8), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      op8(8'h01, 8'h01, 1'b0, lat);
      check("post_rst_lat", 32'(lat), 32'd8);
      check("post_rst_sum", 32'(s8), 32'h02);
      ack8();

      // Exhaustive sweep on the 4-bit, 2-bit-digit instance
      for (int v = 0; v < 512; v++) begin
         logic [8:0] vec;
         vec = 9'(v);
         @(negedge clk);
         a4 = vec[8:5]; b4 = vec[4:1]; cin4 = vec[0]; iv4 = 1'b1;
         exp4 = 5'(vec[8:5]) + 5'(vec[4:1]) + 5'(vec[0]);
         @(posedge clk);
         @(negedge clk);
         iv4 = 1'b0;
         lat = 0;
         while (!ov4 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
         end
         check("sweep_lat", 32'(lat), 32'd2);
         check("sweep_result", 32'({co4, s4}), 32'(exp4));
         or4 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         or4 = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
